lfsr_seq_ctrl: RTL and testbench

- Instruction sequencer for the 8-bit LFSR pattern-generator datapath.
- Fetches 14-bit instructions from the instruction ROM and decodes them into one-cycle strobes for the LFSR datapath: tap load, seed load and single-step.
- Runs run_L as a counted sequence of single steps, and owns the pattern-memory address register.
- Drives a req/ack handshake to the 256x8 pattern memory. Sits between the instruction ROM and the LFSR/memory datapath.

---
 rtl/lfsr_pkg.sv | 48 ++++
 rtl/lfsr_seq_decode.sv | 38 +++
 rtl/lfsr_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern-generator sequencer: opcodes,
// FSM state encoding, memory write-source selects and instruction layout.
package lfsr_pkg;

  localparam logic [5:0] OP_CFG_TAP   = 6'h01;
  localparam logic [5:0] OP_INIT_L    = 6'h02;
  localparam logic [5:0] OP_RUN_L     = 6'h03;
  localparam logic [5:0] OP_STORE     = 6'h04;
  localparam logic [5:0] OP_LOAD      = 6'h05;
  localparam logic [5:0] OP_INIT_ADDR = 6'h06;
  localparam logic [5:0] OP_ADD_ADDR  = 6'h07;
  localparam logic [5:0] OP_STORE_HD  = 6'h09;
  localparam logic [5:0] OP_STORE_AVG = 6'h0A;
  localparam logic [5:0] OP_HALT      = 6'h3F;

  localparam logic [1:0] SEL_Q   = 2'd0;
  localparam logic [1:0] SEL_HD  = 2'd1;
  localparam logic [1:0] SEL_AVG = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_RUN   = 3'd3,
    ST_MEM   = 3'd4,
    ST_HALT  = 3'd5
  } ctrl_state_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic       shamt;
    logic [6:0] funct;
  } instr_t;

  // Control vector produced by the decoder for the instruction held in IR.
  typedef struct packed {
    logic       tap_we;
    logic       seed_we;
    logic       run;
    logic       set_addr;
    logic       add_addr;
    logic       mem;
    logic       mem_we;
    logic [1:0] mem_sel;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/lfsr_seq_decode.sv
// Combinational decoder: turns the instruction register into a control vector.
module lfsr_seq_decode
  import lfsr_pkg::*;
(
  input  instr_t ir,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (ir.opcode)
      OP_CFG_TAP:   ctrl.tap_we   = ~ir.shamt;
      OP_INIT_L:    ctrl.seed_we  = 1'b1;
      OP_RUN_L:     ctrl.run      = 1'b1;
      OP_INIT_ADDR: ctrl.set_addr = 1'b1;
      OP_ADD_ADDR:  ctrl.add_addr = 1'b1;
      OP_STORE: begin
        ctrl.mem     = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.mem_sel = SEL_Q;
      end
      OP_LOAD:      ctrl.mem      = 1'b1;
      OP_STORE_HD: begin
        ctrl.mem     = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.mem_sel = SEL_HD;
      end
      OP_STORE_AVG: begin
        ctrl.mem     = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.mem_sel = SEL_AVG;
      end
      OP_HALT:      ctrl.halt     = 1'b1;
      default:      ctrl          = '0;
    endcase
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Instruction sequencer for the LFSR pattern generator: fetch/exec FSM, counted
// run_L stepping, pattern-memory address register and req/ack memory handshake.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 14,
  parameter int RUNS_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               tap_we,
  output logic [6:0]         tap_val,
  output logic               seed_we,
  output logic [7:0]         seed_val,
  output logic               step,
  output logic               mem_req,
  output logic               mem_we,
  output logic [1:0]         mem_sel,
  output logic [7:0]         mem_addr,
  input  logic               mem_ack,
  output logic [RUNS_W-1:0]  run_count,
  output logic               busy,
  output logic               halted,
  output ctrl_state_t        dbg_state
);

  // Memory handshake: mem_req rises on entry to MEM and stays high, with
  // mem_we/mem_sel/mem_addr stable, up to and including the cycle mem_ack is
  // sampled high; mem_ack seen in any other state has no effect.

  ctrl_state_t       state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic [7:0]        r_addr_q, r_addr_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_sel_q, mem_sel_d;

  ctrl_t      ctrl;
  logic [7:0] imm8;

  lfsr_seq_decode u_decode (
    .ir   (ir_q),
    .ctrl (ctrl)
  );

  assign imm8 = {ir_q.shamt, ir_q.funct};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    r_addr_d  = r_addr_q;
    runs_d    = runs_q;
    cnt_d     = cnt_q;
    mem_we_d  = mem_we_q;
    mem_sel_d = mem_sel_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = instr_t'(instr_data);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (ctrl.set_addr) r_addr_d = imm8;
        if (ctrl.add_addr) r_addr_d = r_addr_q + imm8;
        if (ctrl.run) begin
          runs_d = runs_q + RUNS_W'(1);
          // run_L 0 behaves as a plain two-cycle instruction.
          if (imm8 != 8'd0) begin
            cnt_d   = imm8;
            pc_d    = pc_q;
            state_d = ST_RUN;
          end
        end
        if (ctrl.mem) begin
          mem_we_d  = ctrl.mem_we;
          mem_sel_d = ctrl.mem_sel;
          pc_d      = pc_q;
          state_d   = ST_MEM;
        end
        if (ctrl.halt) begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      r_addr_q  <= '0;
      runs_q    <= '0;
      cnt_q     <= '0;
      mem_we_q  <= 1'b0;
      mem_sel_q <= SEL_Q;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      r_addr_q  <= r_addr_d;
      runs_q    <= runs_d;
      cnt_q     <= cnt_d;
      mem_we_q  <= mem_we_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  // All outputs are flop values gated only by the current state, so an async
  // reset drops them without waiting for a clock edge.
  assign instr_addr = pc_q;
  assign tap_we     = (state_q == ST_EXEC) && ctrl.tap_we;
  assign tap_val    = ir_q.funct;
  assign seed_we    = (state_q == ST_EXEC) && ctrl.seed_we;
  assign seed_val   = imm8;
  assign step       = (state_q == ST_RUN);
  assign mem_req    = (state_q == ST_MEM);
  assign mem_we     = mem_req && mem_we_q;
  assign mem_sel    = (mem_req && mem_we_q) ? mem_sel_q : SEL_Q;
  assign mem_addr   = r_addr_q;
  assign run_count  = runs_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted     = (state_q == ST_HALT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed programs plus random programs
// checked cycle by cycle against an instruction-level timing model.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  instr_addr;
  logic [13:0] instr_data;
  logic        tap_we;
  logic [6:0]  tap_val;
  logic        seed_we;
  logic [7:0]  seed_val;
  logic        step;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [4:0]  run_count;
  logic        busy;
  logic        halted;
  ctrl_state_t dbg_state;

  logic [13:0] rom [256];
  assign instr_data = rom[instr_addr];

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .tap_we     (tap_we),
    .tap_val    (tap_val),
    .seed_we    (seed_we),
    .seed_val   (seed_val),
    .step       (step),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .run_count  (run_count),
    .busy       (busy),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic       tap_we;
    logic [6:0] tap_val;
    logic       seed_we;
    logic [7:0] seed_val;
    logic       step;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_sel;
    logic [7:0] mem_addr;
    logic [7:0] instr_addr;
    logic [4:0] run_count;
    logic       busy;
    logic       halted;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  logic [OBS_W-1:0] exp_q[$];
  int drv_d_q[$];
  int dir_d_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_pc = 0, m_raddr = 0, m_runs = 0;
  bit m_halted = 0;
  int mcnt = 0;
  int last_steps = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Qualifier-masked view of the outputs: values only meaningful with their strobe.
  function automatic obs_t observe();
    obs_t o;
    o = '0;
    o.tap_we     = tap_we;
    o.tap_val    = tap_we ? tap_val : 7'd0;
    o.seed_we    = seed_we;
    o.seed_val   = seed_we ? seed_val : 8'd0;
    o.step       = step;
    o.mem_req    = mem_req;
    o.mem_we     = mem_req ? mem_we : 1'b0;
    o.mem_sel    = (mem_req && mem_we) ? mem_sel : 2'd0;
    o.mem_addr   = mem_addr;
    o.instr_addr = instr_addr;
    o.run_count  = run_count;
    o.busy       = busy;
    o.halted     = halted;
    return o;
  endfunction

  function automatic obs_t snap(input bit is_busy);
    obs_t o;
    o = '0;
    o.mem_addr   = m_raddr[7:0];
    o.instr_addr = m_pc[7:0];
    o.run_count  = m_runs[4:0];
    o.busy       = is_busy;
    o.halted     = !is_busy && m_halted;
    return o;
  endfunction

  // Instruction-level model: each instruction costs a fetch and an exec cycle,
  // plus N step cycles for run_L N or (ack delay + 1) request cycles for memory ops.
  task automatic build_model();
    obs_t e;
    logic [13:0] ins;
    logic [7:0] v;
    int op, d;
    exp_q.push_back(snap(1'b0));
    m_pc = 0;
    m_halted = 0;
    for (int k = 0; k < 64; k++) begin
      ins = rom[m_pc];
      op  = int'(ins[13:8]);
      v   = ins[7:0];
      exp_q.push_back(snap(1'b1));
      e = snap(1'b1);
      if (op == 1 && !v[7]) begin e.tap_we = 1'b1; e.tap_val = v[6:0]; end
      if (op == 2) begin e.seed_we = 1'b1; e.seed_val = v; end
      exp_q.push_back(e);
      case (op)
        3: begin
          m_runs = (m_runs + 1) % 32;
          for (int i = 0; i < int'(v); i++) begin
            e = snap(1'b1);
            e.step = 1'b1;
            exp_q.push_back(e);
          end
        end
        6: m_raddr = int'(v);
        7: m_raddr = (m_raddr + int'(v)) % 256;
        4, 5, 9, 10: begin
          d = (dir_d_q.size() > 0) ? dir_d_q.pop_front() : int'($urandom_range(0, 3));
          drv_d_q.push_back(d);
          for (int i = 0; i <= d; i++) begin
            e = snap(1'b1);
            e.mem_req = 1'b1;
            e.mem_we  = (op != 5);
            e.mem_sel = (op == 9) ? 2'd1 : (op == 10) ? 2'd2 : 2'd0;
            exp_q.push_back(e);
          end
        end
        63: begin
          m_halted = 1;
          exp_q.push_back(snap(1'b0));
          return;
        end
        default: ;
      endcase
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic drive_ack();
    if (mem_req) begin
      if (drv_d_q.size() == 0 || mcnt >= drv_d_q[0]) begin
        mem_ack = 1'b1;
        if (drv_d_q.size() > 0) void'(drv_d_q.pop_front());
        mcnt = 0;
      end else begin
        mem_ack = 1'b0;
        mcnt++;
      end
    end else begin
      mem_ack = 1'($urandom_range(0, 1));
      mcnt = 0;
    end
  endtask

  // Called at a negedge with the program already in rom.
  task automatic run_prog(input string name);
    obs_t o, e;
    int cyc;
    build_model();
    last_steps = 0;
    mcnt = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      o = observe();
      e = exp_q.pop_front();
      check_eq(name, 64'(o), 64'(e));
      check_eq("onehot", 64'($countones({tap_we, seed_we, step, mem_req}) <= 1), 64'd1);
      if (step) last_steps++;
      start = (cyc == 0) ? 1'b1 : (e.busy && $urandom_range(0, 7) == 0);
      drive_ack();
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    drv_d_q.delete();
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 14'h0000;
  endtask

  function automatic logic [13:0] rand_instr();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 9))
      0: return {6'h01, v};
      1: return {6'h02, v};
      2: return {6'h03, 8'($urandom_range(0, 20))};
      3: return {6'h06, v};
      4: return {6'h07, v};
      5: return {6'h04, v};
      6: return {6'h05, v};
      7: return {6'h09, v};
      8: return {6'h0A, v};
      default: return {6'($urandom_range(0, 62)), v};
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    mem_ack = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_strobes", 64'({tap_we, seed_we, step, mem_req}), 64'd0);
    check_eq("rst_pc", 64'(instr_addr), 64'd0);
    check_eq("rst_raddr", 64'(mem_addr), 64'd0);
    check_eq("rst_runs", 64'(run_count), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // basic program: tap, seed, run_L 0, halt
    clear_rom();
    rom[0] = 14'h0125; rom[1] = 14'h02CC; rom[2] = 14'h0300; rom[3] = 14'h3FFF;
    run_prog("prog_a");
    check_eq("a_steps", 64'(last_steps), 64'd0);
    check_eq("a_runs", 64'(run_count), 64'd1);
    check_eq("a_halted", 64'(halted), 64'd1);
    check_eq("a_pc", 64'(instr_addr), 64'd3);

    // run_L 2 and run_L 255
    clear_rom();
    rom[0] = 14'h0302; rom[1] = 14'h03FF; rom[2] = 14'h3FFF;
    run_prog("prog_b");
    check_eq("b_steps", 64'(last_steps), 64'd257);
    check_eq("b_runs", 64'(run_count), 64'd3);

    // address wrap and all memory op flavours with chosen ack delays
    clear_rom();
    rom[0] = 14'h0603; rom[1] = 14'h07FF; rom[2] = 14'h0400; rom[3] = 14'h0500;
    rom[4] = 14'h0900; rom[5] = 14'h0A00; rom[6] = 14'h3FFF;
    dir_d_q = '{3, 0, 1, 2};
    run_prog("prog_c");
    check_eq("c_addr", 64'(mem_addr), 64'h02);

    // NOPs and restart from HALT keep run_count
    clear_rom();
    rom[0] = 14'h2A00; rom[1] = 14'h0180; rom[2] = 14'h2A55; rom[3] = 14'h3FFF;
    run_prog("prog_d");
    check_eq("d_runs", 64'(run_count), 64'd3);
    check_eq("d_pc", 64'(instr_addr), 64'd3);

    for (int p = 0; p < 20; p++) begin
      int len;
      clear_rom();
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) rom[i] = rand_instr();
      rom[len] = 14'h3FFF;
      run_prog("prog_rand");
    end

    // async reset in the middle of run_L 10
    clear_rom();
    rom[0] = 14'h030A; rom[1] = 14'h3FFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (step) n++;
    end
    check_eq("r_steps4", 64'(n), 64'd4);
    @(posedge clk);
    #2;
    check_eq("r_step_pre", 64'(step), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("r_step", 64'(step), 64'd0);
    check_eq("r_busy", 64'(busy), 64'd0);
    check_eq("r_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("r_pc", 64'(instr_addr), 64'd0);
    check_eq("r_runs", 64'(run_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("r_nostep", 64'({step, busy}), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
